// File: rtl/ohc11_pkg.sv
// One-hot mod-11 residue types and helpers shared by the RNS adder slice.
package ohc11_pkg;

  localparam int unsigned OHC_W   = 11;
  localparam int unsigned RNS_MOD = 11;

  // Bit k set means residue k.
  typedef logic [OHC_W-1:0] ohc11_t;

  // Operand pair captured by the operand stage.
  typedef struct packed {
    ohc11_t a;
    ohc11_t b;
  } ohc11_pair_t;

  // A legal residue has exactly one bit set.
  function automatic logic ohc11_is_legal(input ohc11_t x);
    return $countones(x) == 1;
  endfunction

endpackage

// File: rtl/ohc_11_modulo_adder.sv
// Combinational one-hot mod-11 adder.
// Ports: a, b - one-hot residues; sum - one-hot (a+b) mod 11.
// For illegal (non-one-hot) inputs the result is meaningless; callers mask it.
module ohc_11_modulo_adder
  import ohc11_pkg::*;
(
  input  ohc11_t a,
  input  ohc11_t b,
  output ohc11_t sum
);

  logic [3:0] k;

  // Cross-product of set bits: residue i plus residue j lands on (i+j) mod 11.
  always_comb begin
    sum = '0;
    k   = '0;
    for (int i = 0; i < int'(OHC_W); i++) begin
      for (int j = 0; j < int'(OHC_W); j++) begin
        k = 4'((i + j) % int'(RNS_MOD));
        if (a[i] && b[j]) sum[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
// Ports: clk, rst (sync, active-high); req - request vector; en - grant enable;
//        grant - one-hot grant (combinational); gnt_id - index of the grant.
// Pointer moves to one past the winner only when a grant is issued.
module rr_arbiter #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  gnt_id
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] idx;
  logic           found;

  // Scan from the pointer, wrapping modulo NREQ; first valid request wins.
  always_comb begin
    grant  = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      idx = IDW'((int'(ptr) + k) % int'(NREQ));
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gnt_id     = idx;
      end
    end
  end

  // Pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

endmodule

// File: rtl/ohc_11_adder_arbiter.sv
// Shares one one-hot mod-11 adder among NREQ requesters.
// Round-robin grant -> operand stage (S0) -> result stage (S1) with backpressure.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   per-requester handshake (req_ready is combinational)
//   req_a, req_b          packed operands, requester i at bits [11i+10:11i]
//   res_valid/res_ready   result handshake
//   res_data, res_id      one-hot sum and requester index
//   res_err               an operand was not exactly one-hot (res_data = 0)
//   op_count, err_count   delivered results / delivered errored results
module ohc_11_adder_arbiter
  import ohc11_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  parameter  int unsigned CNTW = 16,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*OHC_W-1:0] req_a,
  input  logic [NREQ*OHC_W-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  res_valid,
  output ohc11_t                res_data,
  output logic [IDW-1:0]        res_id,
  output logic                  res_err,
  input  logic                  res_ready,
  output logic [CNTW-1:0]       op_count,
  output logic [CNTW-1:0]       err_count
);

  logic           s0_valid;
  ohc11_pair_t    s0_opnd;
  logic [IDW-1:0] s0_id;

  logic            s1_free;
  logic            s0_free;
  logic            arb_en;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gnt_id;
  ohc11_pair_t     sel_opnd;
  ohc11_t          sum;
  logic            opnd_ok;

  // Stage availability; a stage is free if empty or its contents leave this cycle.
  assign s1_free = !res_valid || res_ready;
  assign s0_free = !s0_valid || s1_free;
  // No grants are shown while reset is held.
  assign arb_en  = s0_free && !rst;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .en     (arb_en),
    .grant  (grant),
    .gnt_id (gnt_id)
  );

  assign req_ready = grant;

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_opnd = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant[i]) begin
        sel_opnd.a = req_a[i*OHC_W +: OHC_W];
        sel_opnd.b = req_b[i*OHC_W +: OHC_W];
      end
    end
  end

  ohc_11_modulo_adder u_add (
    .a   (s0_opnd.a),
    .b   (s0_opnd.b),
    .sum (sum)
  );

  assign opnd_ok = ohc11_is_legal(s0_opnd.a) && ohc11_is_legal(s0_opnd.b);

  // Pipeline and statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid  <= 1'b0;
      s0_opnd   <= '0;
      s0_id     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      res_err   <= 1'b0;
      op_count  <= '0;
      err_count <= '0;
    end else begin
      if (s1_free) begin
        res_valid <= s0_valid;
        if (s0_valid) begin
          res_data <= opnd_ok ? sum : '0;
          res_err  <= !opnd_ok;
          res_id   <= s0_id;
        end
      end
      if (s0_free) begin
        s0_valid <= |grant;
        if (|grant) begin
          s0_opnd <= sel_opnd;
          s0_id   <= gnt_id;
        end
      end
      if (res_valid && res_ready) begin
        op_count <= op_count + 1'b1;
        if (res_err) err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: doc/ohc_11_adder_arbiter.md
Name: ohc_11_adder_arbiter

Overview:
Shares one combinational one-hot mod-11 adder (ohc_11_modulo_adder) among NREQ requesters in the RNS datapath. Round-robin arbitration selects one request per cycle. A two-stage pipeline with backpressure (operand register, then result register) feeds a single tagged result port. Illegal (non-one-hot) operands are flagged and counted.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, $clog2(NREQ), requester-id width (derived, not overridable)
CNTW, 16, width of statistics counters

Ports:
clk  in  1  clock, rising-edge
rst  in  1  synchronous, active-high reset
req_valid  in  NREQ  request i valid
req_a  in  NREQ*11  operand A for requester i, bits [11i+10:11i], one-hot residue
req_b  in  NREQ*11  operand B, same packing
req_ready  out  NREQ  request i accepted this cycle (valid&ready = transfer)
res_valid  out  1  result valid
res_data  out  11  one-hot residue of (A+B) mod 11; bit k set = residue k
res_id  out  IDW  requester index of this result
res_err  out  1  an operand was not exactly one-hot
res_ready  in  1  downstream accepts result
op_count  out  CNTW  results delivered since reset
err_count  out  CNTW  results delivered with res_err=1

Behaviour:
- One clock; reset synchronous, active-high. Reset values: req_ready=0, res_valid=0, res_data=0, res_id=0, res_err=0, op_count=0, err_count=0, RR pointer=0, s0_valid=0.
- Encoding: one-hot, bit k = residue k (0..10). Legal operand has exactly one bit set.
- Stage S0 (operand reg): s0_valid, s0_a, s0_b, s0_id. Stage S1 = output regs res_*.
- s1_free = !res_valid | res_ready; s0_free = !s0_valid | s1_free.
- Arbitration (combinational): when s0_free, grant the first valid requester at or after the RR pointer (modulo NREQ); req_ready = that one-hot grant, else all 0. req_ready never asserted while !s0_free. req_ready does not depend on res_ready except through s0_free.
- On grant to i: S0 captures req_a/req_b slice i and id i; pointer <= (i+1) mod NREQ. No grant -> pointer unchanged.
- S0->S1 when s0_valid & s1_free: res_data <= adder(s0_a, s0_b) if both legal, else 11'b0; res_err <= !(legal(a)&legal(b)); res_id <= s0_id; res_valid <= 1. If s1_free and !s0_valid, res_valid <= 0.
- Latency: request transfer at cycle t -> res_valid at t+2 when unstalled. Throughput 1 result/cycle.
- Backpressure: while res_valid & !res_ready, res_data/res_id/res_err hold stable; S0 holds; no further grants once S0 full.
- Simultaneous: S1 drain, S0->S1 advance and new grant all in the same cycle are legal (full throughput).
- Counters: on res_valid & res_ready, op_count++; also err_count++ if res_err. Both wrap at 2^CNTW.
- Requesters must hold valid/operands until ready; dropping valid before grant is permitted (no request lost or duplicated by the block).
- Reset mid-operation: in-flight S0/S1 contents discarded, no result emitted for them.

Decomposition:
- Package ohc11_pkg: OHC_W=11, RNS_MOD=11, typedef logic [10:0] ohc11_t, function ohc11_is_legal (popcount==1).
- Sub-module rr_arbiter (NREQ request in, one-hot grant out, pointer register, advance enable). Adder instantiated once.

Test Plan:
- Single req0: a=0x080 (7), b=0x040 (6) -> 2 cycles later res_valid=1, res_data=0x004 (2), res_id=0, res_err=0; op_count=1.
- Wrap: a=0x400, b=0x400 (10+10) -> res_data=0x200 (9); a=0x002, b=0x400 (1+10) -> 0x001 (0).
- All NREQ=4 valid continuously, res_ready=1 -> grants 0,1,2,3,0,... one per cycle; res_id follows the same order; no gaps.
- Backpressure: res_ready=0 for 5 cycles with 3 requests pending -> res_* stable, exactly one more request accepted into S0, then req_ready=0; release -> results delivered in order, none lost.
- Illegal: a=0x003, b=0x001 -> res_err=1, res_data=0x000, err_count=1; a=0x000 also flagged.
- Reset mid-stream with S0 and S1 full -> next cycle res_valid=0, counters 0, next grant goes to lowest-index valid requester.
